traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Lamp-side checker for the pedestrian-crossing controller. Samples the six lamp lines and the
//  request button, reconstructs the controller phase (including phases with identical lamp
//  patterns), counts crossings, and raises sticky error flags on any protocol violation.
//  Sits beside the controller in the top-level and bench; it only observes and never drives.
// PARAMETERS
//  CNT_W     8  width of crossing_count (saturating)
//  MAX_HOLD  1  cycles each transient phase (CAR_STOP..CAR_READY) must be held, exactly
//  MAX_WAIT  1  max cycles CAR_GO may persist after a request is seen
// PORTS
//  clk             in   1      single clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  button          in   1      pedestrian request, as seen by the controller
//  green_c         in   1      car lamps
//  yellow_c        in   1
//  red_c           in   1
//  green_p         in   1      pedestrian lamps
//  yellow_p        in   1
//  red_p           in   1
//  locked          out  1      monitor synchronised to controller phase
//  phase           out  3      reconstructed phase (codes below); valid when locked
//  crossing_count  out  CNT_W  PED_GO entries since reset, saturating at all-ones
//  err_any         out  1      sticky OR of all errors
//  err_code        out  3      first error seen (0 = none), held until rst
// BEHAVIOUR
//  - Phase codes: CAR_GO 000, CAR_STOP 001, PED_READY 010, PED_GO 011, PED_STOP 110, CAR_READY 101.
//  - Lamp classes: GC = green_c&red_p; YC = yellow_c&red_p; GP = red_c&green_p;
//    YP = red_c&yellow_p; all other lamps 0. Any other pattern (incl. all-off) = ILLEGAL.
//  - Legal sequence: CAR_GO(GC) -> CAR_STOP(YC) -> PED_READY(YP) -> PED_GO(GP) -> PED_STOP(YP)
//    -> CAR_READY(YC) -> CAR_GO. YP/YC are disambiguated by the previous phase, not by lamps.
//  - All outputs registered; they reflect the lamps sampled on the previous rising edge.
//  - Reset: locked=0, phase=000, crossing_count=0, err_any=0, err_code=0, request latch clear,
//    dwell counter 0. rst asserted mid-sequence discards lock and all history.
//  - UNLOCKED: no checking. First sample of class GC -> locked=1, phase=CAR_GO, dwell=1.
//  - LOCKED, per sample: classify, compare with the expected successor of phase.
//    Same class as current phase -> dwell+1. Successor class -> advance phase, dwell=1.
//  - Request latch: set when button=1 is sampled with phase=CAR_GO; cleared on leaving CAR_GO.
//  - Error codes: 1 ILLEGAL (bad lamp pattern); 2 SEQUENCE (legal class but not current/successor);
//    3 UNREQUESTED (CAR_GO->CAR_STOP with latch clear and button=0 on the prior sample);
//    4 DWELL (transient phase held >MAX_HOLD cycles, or left before MAX_HOLD);
//    5 WAIT (CAR_GO held >MAX_WAIT cycles after the latch set).
//  - Any error: err_any=1 (sticky); err_code loaded only if currently 0.
//    Same-cycle errors: lowest code wins.
//  - ILLEGAL or SEQUENCE -> locked=0, re-sync on next GC. DWELL/UNREQUESTED/WAIT keep lock and
//    track the observed phase.
//  - crossing_count +1 on each CAR_STOP->...->PED_GO entry while locked; holds at 2^CNT_W-1.
//  - dwell counter saturates at MAX_HOLD+1 (no wrap); CAR_GO dwell is unbounded and unchecked
//    unless the latch is set.
// STRUCTURE
//  - traffic_pkg: phase code localparams, error code localparams, next_phase() function.
//  - Sub-module traffic_lamp_classify: combinational 6-lamp -> {GC,YC,YP,GP,ILLEGAL} decode.
//  - Top holds the phase FSM, dwell/wait counters, request latch, error capture and crossing counter.
// TESTING
//  1. rst, then GC x5 with button=0 -> locked=1, phase=000, err_any=0, count=0.
//  2. Full cycle GC(btn=1),YC,YP,GP,YP,YC,GC, one cycle each -> phases 000,001,010,011,110,101,000;
//     count=1; err_any=0.
//  3. GC then YC with button never high -> err_code=3, locked stays 1.
//  4. GP sample directly after GC -> err_code=2, locked=0; next GC re-locks; err_code remains 2.
//  5. Lamps green_c&green_p -> err_code=1. Same cycle as a dwell fault -> err_code=1 (priority).
//  6. CNT_W=2, four clean cycles -> count 1,2,3,3 (saturates). rst mid-PED_GO -> all outputs 0
//     next cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase/error encodings and phase helpers for the
// pedestrian-crossing lamp monitor.
package traffic_pkg;

  typedef enum logic [2:0] {
    CAR_GO    = 3'b000,
    CAR_STOP  = 3'b001,
    PED_READY = 3'b010,
    PED_GO    = 3'b011,
    PED_STOP  = 3'b110,
    CAR_READY = 3'b101
  } phase_e;

  localparam logic [2:0] PH_CAR_GO    = 3'b000;
  localparam logic [2:0] PH_CAR_STOP  = 3'b001;
  localparam logic [2:0] PH_PED_READY = 3'b010;
  localparam logic [2:0] PH_PED_GO    = 3'b011;
  localparam logic [2:0] PH_PED_STOP  = 3'b110;
  localparam logic [2:0] PH_CAR_READY = 3'b101;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
  localparam logic [2:0] ERR_SEQUENCE = 3'd2;
  localparam logic [2:0] ERR_UNREQ    = 3'd3;
  localparam logic [2:0] ERR_DWELL    = 3'd4;
  localparam logic [2:0] ERR_WAIT     = 3'd5;

  // One-hot lamp class; ill set for any non-legal pattern.
  typedef struct packed {
    logic gc;
    logic yc;
    logic yp;
    logic gp;
    logic ill;
  } lamp_cls_t;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      CAR_GO:    return CAR_STOP;
      CAR_STOP:  return PED_READY;
      PED_READY: return PED_GO;
      PED_GO:    return PED_STOP;
      PED_STOP:  return CAR_READY;
      CAR_READY: return CAR_GO;
      default:   return CAR_GO;
    endcase
  endfunction

  // Lamp class that a phase shows; several phases share one.
  function automatic lamp_cls_t phase_class(input phase_e p);
    lamp_cls_t c;
    c = '0;
    case (p)
      CAR_GO:              c.gc  = 1'b1;
      CAR_STOP, CAR_READY: c.yc  = 1'b1;
      PED_READY, PED_STOP: c.yp  = 1'b1;
      PED_GO:              c.gp  = 1'b1;
      default:             c.ill = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/traffic_lamp_classify.sv
// Combinational decode of the six lamp lines into
// a one-hot lamp class.
module traffic_lamp_classify
  import traffic_pkg::*;
(
  input  logic      green_c,
  input  logic      yellow_c,
  input  logic      red_c,
  input  logic      green_p,
  input  logic      yellow_p,
  input  logic      red_p,
  output lamp_cls_t cls
);

  logic [5:0] lamps;

  assign lamps = {green_c, yellow_c, red_c,
                  green_p, yellow_p, red_p};

  // Exact-match decode; anything else is illegal.
  always_comb begin
    cls = '0;
    case (lamps)
      6'b100001: cls.gc  = 1'b1;
      6'b010001: cls.yc  = 1'b1;
      6'b001100: cls.gp  = 1'b1;
      6'b001010: cls.yp  = 1'b1;
      default:   cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp-side protocol checker: tracks the crossing
// controller phase, counts crossings, flags errors.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 1,
  parameter int MAX_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             green_c,
  input  logic             yellow_c,
  input  logic             red_c,
  input  logic             green_p,
  input  logic             yellow_p,
  input  logic             red_p,
  output logic             locked,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] crossing_count,
  output logic             err_any,
  output logic [2:0]       err_code
);

  localparam int DW = $clog2(MAX_HOLD + 2);
  localparam int WW = $clog2(MAX_WAIT + 2);

  localparam logic [DW-1:0] HOLD  = DW'(MAX_HOLD);
  localparam logic [DW-1:0] D_SAT = DW'(MAX_HOLD + 1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [WW-1:0] WLIM  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] W_SAT = WW'(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lamp_cls_t cls;
  lamp_cls_t cur_cls;
  lamp_cls_t succ_cls;
  phase_e    nxt;
  logic      same;
  logic      succ;
  logic      transient;
  logic      in_go;
  logic [5:1] err;
  logic [2:0] first_err;

  logic             locked_q,  locked_d;
  phase_e           phase_q,   phase_d;
  logic [DW-1:0]    dwell_q,   dwell_d;
  logic [WW-1:0]    wait_q,    wait_d;
  logic             latch_q,   latch_d;
  logic             btn_q,     btn_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             err_any_q, err_any_d;
  logic [2:0]       err_q,     err_d;

  traffic_lamp_classify u_classify (
    .green_c  (green_c),
    .yellow_c (yellow_c),
    .red_c    (red_c),
    .green_p  (green_p),
    .yellow_p (yellow_p),
    .red_p    (red_p),
    .cls      (cls)
  );

  // Phase bookkeeping shared by the checks below.
  always_comb begin
    nxt       = next_phase(phase_q);
    cur_cls   = phase_class(phase_q);
    succ_cls  = phase_class(nxt);
    same      = (cls == cur_cls);
    succ      = (cls == succ_cls);
    in_go     = (phase_q == CAR_GO);
    transient = !in_go;
  end

  // Next-state: lock/phase tracking, counters, checks.
  always_comb begin
    locked_d  = locked_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    wait_d    = wait_q;
    latch_d   = latch_q;
    btn_d     = button;
    cnt_d     = cnt_q;
    err_any_d = err_any_q;
    err_d     = err_q;
    err       = '0;
    first_err = ERR_NONE;

    if (!locked_q) begin
      if (cls.gc) begin
        locked_d = 1'b1;
        phase_d  = CAR_GO;
        dwell_d  = D_ONE;
        wait_d   = '0;
        latch_d  = 1'b0;
      end
    end else begin
      if (cls.ill)
        err[1] = 1'b1;
      else if (!same && !succ)
        err[2] = 1'b1;

      // A transient phase must hand over to its
      // successor after exactly MAX_HOLD samples.
      if (transient && !succ && dwell_q >= HOLD)
        err[4] = 1'b1;
      if (transient && succ && dwell_q < HOLD)
        err[4] = 1'b1;

      if (in_go && succ && !latch_q && !btn_q)
        err[3] = 1'b1;
      if (in_go && same && latch_q && wait_q >= WLIM)
        err[5] = 1'b1;

      if (same) begin
        if (dwell_q != D_SAT)
          dwell_d = dwell_q + 1'b1;
        if (in_go) begin
          if (latch_q) begin
            if (wait_q != W_SAT)
              wait_d = wait_q + 1'b1;
          end else if (button) begin
            latch_d = 1'b1;
          end
        end
      end else if (succ) begin
        phase_d = nxt;
        dwell_d = D_ONE;
        wait_d  = '0;
        latch_d = 1'b0;
        if (nxt == PED_GO && cnt_q != CNT_MAX)
          cnt_d = cnt_q + 1'b1;
      end

      // Pattern/sequence faults drop sync entirely.
      if (err[1] || err[2]) begin
        locked_d = 1'b0;
        phase_d  = CAR_GO;
        dwell_d  = '0;
        wait_d   = '0;
        latch_d  = 1'b0;
      end
    end

    if (err[1])      first_err = ERR_ILLEGAL;
    else if (err[2]) first_err = ERR_SEQUENCE;
    else if (err[3]) first_err = ERR_UNREQ;
    else if (err[4]) first_err = ERR_DWELL;
    else if (err[5]) first_err = ERR_WAIT;

    if (|err) begin
      err_any_d = 1'b1;
      if (err_q == ERR_NONE)
        err_d = first_err;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q  <= 1'b0;
      phase_q   <= CAR_GO;
      dwell_q   <= '0;
      wait_q    <= '0;
      latch_q   <= 1'b0;
      btn_q     <= 1'b0;
      cnt_q     <= '0;
      err_any_q <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      locked_q  <= locked_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      wait_q    <= wait_d;
      latch_q   <= latch_d;
      btn_q     <= btn_d;
      cnt_q     <= cnt_d;
      err_any_q <= err_any_d;
      err_q     <= err_d;
    end
  end

  assign locked         = locked_q;
  assign phase          = phase_q;
  assign crossing_count = cnt_q;
  assign err_any        = err_any_q;
  assign err_code       = err_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor:
// per-sample expected outputs queued and compared.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [5:0] lamps;
  logic       green_c, yellow_c, red_c;
  logic       green_p, yellow_p, red_p;
  logic       locked;
  logic [2:0] phase;
  logic [1:0] crossing_count;
  logic       err_any;
  logic [2:0] err_code;

  localparam logic [5:0] L_GC  = 6'b100001;
  localparam logic [5:0] L_YC  = 6'b010001;
  localparam logic [5:0] L_GP  = 6'b001100;
  localparam logic [5:0] L_YP  = 6'b001010;
  localparam logic [5:0] L_BAD = 6'b100100;

  typedef struct packed {
    logic       l;
    logic [2:0] ph;
    logic [1:0] cnt;
    logic       ea;
    logic [2:0] ec;
  } obs_t;

  typedef struct packed {
    logic       r;
    logic [5:0] lp;
    logic       b;
    obs_t       e;
  } row_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign {green_c, yellow_c, red_c,
          green_p, yellow_p, red_p} = lamps;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .CNT_W    (2),
    .MAX_HOLD (1),
    .MAX_WAIT (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button         (button),
    .green_c        (green_c),
    .yellow_c       (yellow_c),
    .red_c          (red_c),
    .green_p        (green_p),
    .yellow_p       (yellow_p),
    .red_p          (red_p),
    .locked         (locked),
    .phase          (phase),
    .crossing_count (crossing_count),
    .err_any        (err_any),
    .err_code       (err_code)
  );

  function automatic row_t rw(
    input logic r, input logic [5:0] lp,
    input logic b, input logic l,
    input logic [2:0] ph, input logic [1:0] c,
    input logic ea, input logic [2:0] ec);
    row_t x;
    x.r = r; x.lp = lp; x.b = b;
    x.e = '{l: l, ph: ph, cnt: c, ea: ea, ec: ec};
    return x;
  endfunction

  task automatic test_reset();
    row_t t[$];
    obs_t got, exp;
    t = '{rw(1, L_GC, 1, 0, 0, 0, 0, 0),
          rw(1, L_BAD, 0, 0, 0, 0, 0, 0)};
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_lock();
    row_t t[$];
    obs_t got, exp;
    for (int k = 0; k < 5; k++)
      t.push_back(rw(0, L_GC, 0, 1, 0, 0, 0, 0));
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL lock[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_full_cycle();
    row_t t[$];
    obs_t got, exp;
    t = '{rw(0, L_GC, 1, 1, 3'b000, 0, 0, 0),
          rw(0, L_YC, 0, 1, 3'b001, 0, 0, 0),
          rw(0, L_YP, 0, 1, 3'b010, 0, 0, 0),
          rw(0, L_GP, 0, 1, 3'b011, 1, 0, 0),
          rw(0, L_YP, 0, 1, 3'b110, 1, 0, 0),
          rw(0, L_YC, 0, 1, 3'b101, 1, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 1, 0, 0)};
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL cycle[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_unrequested();
    row_t t[$];
    obs_t got, exp;
    t = '{rw(1, L_GC, 0, 0, 0, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_YC, 0, 1, 3'b001, 0, 1, 3),
          rw(0, L_YP, 0, 1, 3'b010, 0, 1, 3)};
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL unreq[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_sequence();
    row_t t[$];
    obs_t got, exp;
    t = '{rw(1, L_GC, 0, 0, 0, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_GP, 0, 0, 3'b000, 0, 1, 2),
          rw(0, L_YC, 0, 0, 3'b000, 0, 1, 2),
          rw(0, L_GC, 0, 1, 3'b000, 0, 1, 2)};
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL seq[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_illegal();
    row_t t[$];
    obs_t got, exp;
    t = '{rw(1, L_GC, 0, 0, 0, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_BAD, 0, 0, 3'b000, 0, 1, 1),
          rw(0, L_GC, 0, 1, 3'b000, 0, 1, 1),
          rw(1, L_GC, 0, 0, 0, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_GC, 1, 1, 3'b000, 0, 0, 0),
          rw(0, L_YC, 0, 1, 3'b001, 0, 0, 0),
          rw(0, L_BAD, 0, 0, 3'b000, 0, 1, 1)};
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL illegal[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_dwell_wait();
    row_t t[$];
    obs_t got, exp;
    t = '{rw(1, L_GC, 0, 0, 0, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_GC, 1, 1, 3'b000, 0, 0, 0),
          rw(0, L_YC, 0, 1, 3'b001, 0, 0, 0),
          rw(0, L_YC, 0, 1, 3'b001, 0, 1, 4),
          rw(0, L_YP, 0, 1, 3'b010, 0, 1, 4),
          rw(1, L_GC, 0, 0, 0, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_GC, 1, 1, 3'b000, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0),
          rw(0, L_GC, 0, 1, 3'b000, 0, 1, 5)};
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL dwell[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_saturate();
    row_t t[$];
    obs_t got, exp;
    logic [1:0] c0, c1;
    t.push_back(rw(1, L_GC, 0, 0, 0, 0, 0, 0));
    t.push_back(rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      c0 = (k > 3) ? 2'd3 : 2'(k);
      c1 = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
      t.push_back(rw(0, L_GC, 1, 1, 3'b000, c0, 0, 0));
      t.push_back(rw(0, L_YC, 0, 1, 3'b001, c0, 0, 0));
      t.push_back(rw(0, L_YP, 0, 1, 3'b010, c0, 0, 0));
      t.push_back(rw(0, L_GP, 0, 1, 3'b011, c1, 0, 0));
      if (k < 3) begin
        t.push_back(rw(0, L_YP, 0, 1, 3'b110, c1, 0, 0));
        t.push_back(rw(0, L_YC, 0, 1, 3'b101, c1, 0, 0));
      end
    end
    t.push_back(rw(1, L_GP, 0, 0, 0, 0, 0, 0));
    t.push_back(rw(0, L_GC, 0, 1, 3'b000, 0, 0, 0));
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      rst = t[i].r; lamps = t[i].lp; button = t[i].b;
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {locked, phase, crossing_count, err_any, err_code};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL sat[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    button = 1'b0;
    lamps = L_GC;
    test_reset();
    test_lock();
    test_full_cycle();
    test_unrequested();
    test_sequence();
    test_illegal();
    test_dwell_wait();
    test_saturate();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
